// File: rtl/framed_delay_shift_register_if.sv
// framed_delay_shift_register_if
//   Groups the control, serial data and word-output signals of
//   framed_delay_shift_register. CLK and RST stay plain ports on the block.
//   Ports (master = stimulus side, slave = the shift register):
//     CLR, EN, WORD_MODE, DATA_IN, TAP_SEL[TAP_W]  master -> slave
//     BIT_OUT, WORD_OUT[WORD_W], WORD_STB, PRIMED  slave  -> master
interface framed_delay_shift_register_if #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 12,
  parameter int TAP_W  = $clog2(DEPTH)
);
  logic              CLR;
  logic              EN;
  logic              WORD_MODE;
  logic              DATA_IN;
  logic [TAP_W-1:0]  TAP_SEL;
  logic              BIT_OUT;
  logic [WORD_W-1:0] WORD_OUT;
  logic              WORD_STB;
  logic              PRIMED;

  modport master (
    output CLR, EN, WORD_MODE, DATA_IN, TAP_SEL,
    input  BIT_OUT, WORD_OUT, WORD_STB, PRIMED
  );

  modport slave (
    input  CLR, EN, WORD_MODE, DATA_IN, TAP_SEL,
    output BIT_OUT, WORD_OUT, WORD_STB, PRIMED
  );
endinterface

// File: rtl/framed_delay_shift_register.sv
// framed_delay_shift_register
//   Serial-to-parallel shift register feeding a DEPTH-stage word delay line.
//   Serial bits (MSB first) are assembled in a WORD_W-bit register; the delay
//   line either advances every enabled cycle (per-bit mode) or once per
//   completed word (framed mode, with a one-cycle WORD_STB).
//   Ports:
//     CLK  - clock, all state on the rising edge
//     RST  - asynchronous active-high reset
//     bus  - slave modport: CLR (sync clear, beats EN), EN, WORD_MODE,
//            DATA_IN, TAP_SEL in; BIT_OUT, WORD_OUT, WORD_STB, PRIMED out
//   Build option:
//     FDSR_TAP_SEL_EN - when defined, WORD_OUT = stage[TAP_SEL] (clamped to
//                       the last stage); otherwise WORD_OUT is always the last
//                       stage and TAP_SEL is ignored.
module framed_delay_shift_register #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 12,
  parameter int TAP_W  = $clog2(DEPTH)
) (
  input logic                          CLK,
  input logic                          RST,
  framed_delay_shift_register_if.slave bus
);

  localparam int CNT_W  = $clog2(WORD_W);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WORD_W-1:0] bitreg_q, bitreg_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [WORD_W-1:0] stage_q [DEPTH];
  logic [WORD_W-1:0] stage_d [DEPTH];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              stb_q, stb_d;

  logic              word_done;
  logic              advance;
  logic [WORD_W-1:0] shifted;

  // Word phase comes from bcnt alone, so a WORD_MODE change mid-word still
  // completes on the existing bit phase.
  assign word_done = bus.EN && (bcnt_q == LAST_BIT);
  assign shifted   = {bitreg_q[WORD_W-2:0], bus.DATA_IN};
  assign advance   = bus.EN && (!bus.WORD_MODE || word_done);

  // NOTE: every always_comb output gets a default first, otherwise the
  // untaken branches would infer latches.
  always_comb begin
    bitreg_d = bitreg_q;
    bcnt_d   = bcnt_q;
    stage_d  = stage_q;
    fill_d   = fill_q;
    stb_d    = 1'b0;   // strobe is a single-cycle pulse, even with EN low

    if (bus.CLR) begin
      bitreg_d = '0;
      bcnt_d   = '0;
      fill_d   = '0;
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    end else if (bus.EN) begin
      bitreg_d = shifted;
      bcnt_d   = word_done ? '0 : bcnt_q + 1'b1;
      stb_d    = bus.WORD_MODE && word_done;
      if (advance) begin
        for (int i = DEPTH - 1; i > 0; i--) stage_d[i] = stage_q[i-1];
        // Per-bit mode loads the pre-shift register; framed mode loads the
        // word including the bit arriving on this edge.
        stage_d[0] = bus.WORD_MODE ? shifted : bitreg_q;
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bitreg_q <= '0;
      bcnt_q   <= '0;
      fill_q   <= '0;
      stb_q    <= 1'b0;
      // NOTE: the delay line is reset too: WORD_OUT must read zero
      // straight out of reset, so it cannot be left as an unreset RAM.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      bitreg_q <= bitreg_d;
      bcnt_q   <= bcnt_d;
      fill_q   <= fill_d;
      stb_q    <= stb_d;
      stage_q  <= stage_d;
    end
  end

  assign bus.BIT_OUT  = bitreg_q[WORD_W-1];
  assign bus.WORD_STB = stb_q;
  assign bus.PRIMED   = (fill_q == FILL_MAX);

`ifdef FDSR_TAP_SEL_EN
  logic [TAP_W-1:0] tap_sel;
  assign tap_sel = bus.TAP_SEL;

  // Out-of-range taps clamp to the last stage.
  always_comb begin
    if (int'(tap_sel) >= DEPTH) bus.WORD_OUT = stage_q[DEPTH-1];
    else                        bus.WORD_OUT = stage_q[tap_sel];
  end
`else
  logic [TAP_W-1:0] unused_tap_sel;
  assign unused_tap_sel = bus.TAP_SEL;
  assign bus.WORD_OUT   = stage_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_framed_delay_shift_register.sv
// tb_framed_delay_shift_register
//   Directed bench for framed_delay_shift_register (WORD_W=8, DEPTH=12).
//   A reference model predicts the outputs for every driven edge; predictions
//   are queued and compared after the edge, alongside fixed expectations for
//   the key scenarios. Honours FDSR_TAP_SEL_EN in the same way as the design.
module tb_framed_delay_shift_register;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 12;

  typedef struct {
    logic       bit_out;
    logic [7:0] word_out;
    logic       stb;
    logic       primed;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  framed_delay_shift_register_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  framed_delay_shift_register #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Reference model state
  logic [7:0] m_bitreg;
  int         m_bcnt;
  logic [7:0] m_stage [DEPTH];
  int         m_fill;
  logic       m_stb;
  logic [3:0] tap_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bitreg = '0;
    m_bcnt   = 0;
    m_fill   = 0;
    m_stb    = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stage[i] = '0;
  endtask

  task automatic model_edge(input logic clr, input logic en, input logic mode, input logic din);
    logic [7:0] sh;
    logic       done;
    sh    = {m_bitreg[6:0], din};
    done  = en && (m_bcnt == WORD_W - 1);
    m_stb = 1'b0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      if (!mode || done) begin
        for (int i = DEPTH - 1; i > 0; i--) m_stage[i] = m_stage[i-1];
        m_stage[0] = mode ? sh : m_bitreg;
        if (m_fill < DEPTH) m_fill++;
      end
      m_bitreg = sh;
      m_bcnt   = done ? 0 : m_bcnt + 1;
      m_stb    = mode && done;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   t;
`ifdef FDSR_TAP_SEL_EN
    t = (int'(tap_drv) >= DEPTH) ? DEPTH - 1 : int'(tap_drv);
`else
    t = DEPTH - 1;
`endif
    e.bit_out  = m_bitreg[7];
    e.word_out = m_stage[t];
    e.stb      = m_stb;
    e.primed   = (m_fill == DEPTH);
    return e;
  endfunction

  // One clock: drive inputs, queue the prediction, compare after the edge.
  task automatic step(input logic clr, input logic en, input logic mode,
                      input logic din, input logic [3:0] tap);
    exp_t e;
    @(negedge CLK);
    bus.CLR       = clr;
    bus.EN        = en;
    bus.WORD_MODE = mode;
    bus.DATA_IN   = din;
    bus.TAP_SEL   = tap;
    tap_drv       = tap;
    model_edge(clr, en, mode, din);
    sb.push_back(model_out());
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("sb_bit_out",  32'(bus.BIT_OUT),  32'(e.bit_out));
    check("sb_word_out", 32'(bus.WORD_OUT), 32'(e.word_out));
    check("sb_word_stb", 32'(bus.WORD_STB), 32'(e.stb));
    check("sb_primed",   32'(bus.PRIMED),   32'(e.primed));
  endtask

  task automatic send_word(input logic [7:0] w, input logic [3:0] tap);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, 1'b1, w[i], tap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    logic       held;
    logic [7:0] exp_w;

    bus.CLR = 1'b0; bus.EN = 1'b0; bus.WORD_MODE = 1'b0;
    bus.DATA_IN = 1'b0; bus.TAP_SEL = '0; tap_drv = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_bit_out",  32'(bus.BIT_OUT),  32'h0);
    check("rst_word_out", 32'(bus.WORD_OUT), 32'h0);
    check("rst_word_stb", 32'(bus.WORD_STB), 32'h0);
    check("rst_primed",   32'(bus.PRIMED),   32'h0);
    RST = 1'b0;

    // Per-bit pulse through the full line
    for (int e = 1; e <= 14; e++) begin
      step(1'b0, 1'b1, 1'b0, (e == 1), 4'd11);
      check("pb_bit_out", 32'(bus.BIT_OUT), 32'(e == 8));
      if (e == 11) check("pb_primed_11", 32'(bus.PRIMED), 32'h0);
      if (e == 12) check("pb_primed_12", 32'(bus.PRIMED), 32'h1);
      if (e == 12) check("pb_word_12", 32'(bus.WORD_OUT), 32'h00);
      if (e == 13) check("pb_word_13", 32'(bus.WORD_OUT), 32'h01);
      if (e == 14) check("pb_word_14", 32'(bus.WORD_OUT), 32'h02);
    end

    // Clear, then one framed word 0xA5 with TAP_SEL=0
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    check("clr_primed", 32'(bus.PRIMED), 32'h0);
    w = 8'hA5;
`ifdef FDSR_TAP_SEL_EN
    exp_w = 8'hA5;
`else
    exp_w = 8'h00;
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, w[7-i], 4'd0);
      check("fw_stb", 32'(bus.WORD_STB), 32'(i == 7));
      if (i == 7) check("fw_word", 32'(bus.WORD_OUT), 32'(exp_w));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("fw_stb_drop_en_low", 32'(bus.WORD_STB), 32'h0);
    check("fw_word_hold", 32'(bus.WORD_OUT), 32'(exp_w));

    // Framed fill with 0x01..0x0D at tap 11
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd11);
    for (int k = 1; k <= 13; k++) begin
      send_word(8'(k), 4'd11);
      check("ff_stb", 32'(bus.WORD_STB), 32'h1);
      check("ff_primed", 32'(bus.PRIMED), 32'(k >= 12));
      if (k == 12) check("ff_word_12", 32'(bus.WORD_OUT), 32'h01);
      if (k == 13) check("ff_word_13", 32'(bus.WORD_OUT), 32'h02);
    end

    // EN gating mid-word: 3 bits, 5 idle cycles, then 5 bits
    w = 8'h3C;
    for (int i = 7; i >= 5; i--) step(1'b0, 1'b1, 1'b1, w[i], 4'd11);
    held = bus.BIT_OUT;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd11);
      check("en_hold_bit", 32'(bus.BIT_OUT), 32'(held));
      check("en_hold_stb", 32'(bus.WORD_STB), 32'h0);
    end
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b1, w[i], 4'd11);
      check("en_stb", 32'(bus.WORD_STB), 32'(i == 0));
    end
    check("en_word_stage11", 32'(bus.WORD_OUT), 32'h03);

    // Tap clamp: refill with 0x10..0x1B
    for (int k = 0; k < 12; k++) send_word(8'(8'h10 + k), 4'd15);
    check("tap15_word", 32'(bus.WORD_OUT), 32'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
`ifdef FDSR_TAP_SEL_EN
    exp_w = 8'h1B;
`else
    exp_w = 8'h10;
`endif
    check("tap0_word", 32'(bus.WORD_OUT), 32'(exp_w));

    // CLR coincident with a word-complete edge
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'd11);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd11);
    check("clrwc_stb",     32'(bus.WORD_STB), 32'h0);
    check("clrwc_word",    32'(bus.WORD_OUT), 32'h0);
    check("clrwc_primed",  32'(bus.PRIMED),   32'h0);
    check("clrwc_bit_out", 32'(bus.BIT_OUT),  32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd11);
    check("clrwc_no_late_stb", 32'(bus.WORD_STB), 32'h0);

    // Async reset between edges, with a primed line and a word in progress
    for (int k = 0; k < 12; k++) send_word(8'(8'hF0 + k), 4'd11);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 4'd11);
    check("pre_rst_primed", 32'(bus.PRIMED), 32'h1);
    #2;
    RST    = 1'b1;
    bus.EN = 1'b0;
    #1;
    check("arst_bit_out",  32'(bus.BIT_OUT),  32'h0);
    check("arst_word_out", 32'(bus.WORD_OUT), 32'h0);
    check("arst_word_stb", 32'(bus.WORD_STB), 32'h0);
    check("arst_primed",   32'(bus.PRIMED),   32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    // First enabled edge after release is the MSB of a new word
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, w[7-i], 4'd11);
      check("post_rst_stb", 32'(bus.WORD_STB), 32'(i == 7));
    end
    check("post_rst_bit_out", 32'(bus.BIT_OUT), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
